// File: rtl/cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : cond_unit
// Brief    : Conditional-execution stage of the multicycle ARM datapath.
//            Holds NZCV, evaluates the condition field, gates the
//            architectural write enables and counts executed/skipped
//            instructions.
// Revision : 1.0 - initial release
// ============================================================================
module cond_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             NextPC,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             IRWrite,
    input  logic             CntClr,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [3:0]       Flags,
    output logic             CondExDelayed,
    output logic [CNT_W-1:0] ExecCnt,
    output logic [CNT_W-1:0] SkipCnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [3:0]       r_flags_q, w_flags_d;
    logic             r_cond_ex_q;
    logic             r_decode_valid_q;
    logic [CNT_W-1:0] r_exec_cnt_q, w_exec_cnt_d;
    logic [CNT_W-1:0] r_skip_cnt_q, w_skip_cnt_d;
    logic             w_cond_ex;
    logic             w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = r_flags_q;

    always_comb begin
        w_cond_ex = 1'b0;
        case (Cond)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = ~w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = ~w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = ~w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = ~w_v;
            4'b1000: w_cond_ex = w_c & ~w_z;
            4'b1001: w_cond_ex = ~w_c | w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ex = w_z | (w_n != w_v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    // N,Z and C,V halves update independently, only when the condition passes
    always_comb begin
        w_flags_d = r_flags_q;
        if (FlagW[1] && w_cond_ex) w_flags_d[3:2] = ALUFlags[3:2];
        if (FlagW[0] && w_cond_ex) w_flags_d[1:0] = ALUFlags[1:0];
    end

    always_comb begin
        w_exec_cnt_d = r_exec_cnt_q;
        w_skip_cnt_d = r_skip_cnt_q;
        if (CntClr) begin
            w_exec_cnt_d = '0;
            w_skip_cnt_d = '0;
        end else if (r_decode_valid_q) begin
            if (w_cond_ex) begin
                if (r_exec_cnt_q != c_cnt_max) w_exec_cnt_d = r_exec_cnt_q + c_cnt_one;
            end else begin
                if (r_skip_cnt_q != c_cnt_max) w_skip_cnt_d = r_skip_cnt_q + c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags_q        <= 4'b0000;
            r_cond_ex_q      <= 1'b0;
            r_decode_valid_q <= 1'b0;
            r_exec_cnt_q     <= '0;
            r_skip_cnt_q     <= '0;
        end else begin
            r_flags_q        <= w_flags_d;
            r_cond_ex_q      <= w_cond_ex;
            r_decode_valid_q <= IRWrite;
            r_exec_cnt_q     <= w_exec_cnt_d;
            r_skip_cnt_q     <= w_skip_cnt_d;
        end
    end

    // NextPC bypasses the condition so fetch always advances
    assign PCWrite       = (PCS & r_cond_ex_q) | NextPC;
    assign RegWrite      = RegW & r_cond_ex_q;
    assign MemWrite      = MemW & r_cond_ex_q;
    assign Flags         = r_flags_q;
    assign CondExDelayed = r_cond_ex_q;
    assign ExecCnt       = r_exec_cnt_q;
    assign SkipCnt       = r_skip_cnt_q;

endmodule
`default_nettype wire
